// File: rtl/music_sequencer.sv
// music_sequencer: control FSM for the music device datapath.
// Sequences note recording (ld_note) and timed playback (ld_play,
// next_note_en, note_counter, tone_en). It also keeps the stored-note
// count for the 16-entry note memory.
module music_sequencer #(
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned REST_TICKS = 2_500_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       record_req,
  input  logic       play_req,
  input  logic       stop_req,
  input  logic       note_strobe,
  output logic       ld_note,
  output logic       ld_play,
  output logic       next_note_en,
  output logic [3:0] note_counter,
  output logic       display_note,
  output logic       tone_en,
  output logic [4:0] note_total,
  output logic       full,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REC_WAIT    = 3'd1,
    REC_LOAD    = 3'd2,
    REC_GAP     = 3'd3,
    PLAY_LOAD   = 3'd4,
    PLAY_SETTLE = 3'd5,
    PLAY_HOLD   = 3'd6,
    PLAY_REST   = 3'd7
  } state_t;

  // Duration counter reload values; the counter runs down to zero, so a
  // phase of T cycles is loaded with T-1.
  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] REST_LOAD = (REST_TICKS > 0) ? CNT_W'(REST_TICKS - 1) : '0;

  state_t           state_q;
  logic             ld_note_q;
  logic             ld_play_q;
  logic             next_note_en_q;
  logic             display_note_q;
  logic             tone_en_q;
  logic [3:0]       note_counter_q;
  logic [4:0]       note_total_q;
  logic [CNT_W-1:0] dur_q;

  logic [4:0] last_idx;
  logic       is_last;
  logic       full_w;

  // Index of the last stored note, and whether playback has reached it.
  assign last_idx = note_total_q - 5'd1;
  assign is_last  = ({1'b0, note_counter_q} == last_idx);
  assign full_w   = (note_total_q == 5'd16);

  // Single FSM process: state, counters and all registered outputs.
  // Pulse outputs default low each cycle and are set only by the transition
  // that owns them, so every output is valid the cycle after its edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      ld_note_q      <= 1'b0;
      ld_play_q      <= 1'b0;
      next_note_en_q <= 1'b0;
      display_note_q <= 1'b0;
      tone_en_q      <= 1'b0;
      note_counter_q <= 4'd0;
      note_total_q   <= 5'd0;
      dur_q          <= '0;
    end else begin
      ld_note_q      <= 1'b0;
      next_note_en_q <= 1'b0;
      display_note_q <= 1'b0;
      tone_en_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          ld_play_q <= 1'b0;
          if (stop_req) begin
            state_q <= IDLE;
          end else if (play_req && note_total_q != 5'd0) begin
            state_q        <= PLAY_LOAD;
            note_counter_q <= 4'd0;
            ld_play_q      <= 1'b1;
            next_note_en_q <= 1'b1;
            display_note_q <= 1'b1;
          end else if (record_req) begin
            state_q <= REC_WAIT;
          end
        end
        REC_WAIT: begin
          if (stop_req) begin
            state_q <= IDLE;
          end else if (play_req && note_total_q != 5'd0) begin
            state_q        <= PLAY_LOAD;
            note_counter_q <= 4'd0;
            ld_play_q      <= 1'b1;
            next_note_en_q <= 1'b1;
            display_note_q <= 1'b1;
          end else if (note_strobe && !full_w) begin
            state_q        <= REC_LOAD;
            ld_note_q      <= 1'b1;
            display_note_q <= 1'b1;
            note_total_q   <= note_total_q + 5'd1;
          end
        end
        // Write strobe then one quiet cycle; strobes arriving here are dropped.
        REC_LOAD: state_q <= REC_GAP;
        REC_GAP:  state_q <= REC_WAIT;
        default: begin
          if (stop_req) begin
            // Park: point the datapath back at the last stored note so the
            // next append lands at note_total.
            state_q        <= IDLE;
            ld_play_q      <= 1'b1;
            next_note_en_q <= 1'b1;
            display_note_q <= 1'b1;
            note_counter_q <= last_idx[3:0];
          end else begin
            case (state_q)
              PLAY_LOAD: state_q <= PLAY_SETTLE;
              PLAY_SETTLE: begin
                state_q   <= PLAY_HOLD;
                dur_q     <= NOTE_LOAD;
                tone_en_q <= 1'b1;
              end
              PLAY_HOLD: begin
                if (dur_q != '0) begin
                  dur_q     <= dur_q - CNT_W'(1);
                  tone_en_q <= 1'b1;
                end else if (is_last) begin
                  state_q   <= IDLE;
                  ld_play_q <= 1'b0;
                end else begin
                  note_counter_q <= note_counter_q + 4'd1;
                  if (REST_TICKS == 0) begin
                    state_q        <= PLAY_LOAD;
                    next_note_en_q <= 1'b1;
                    display_note_q <= 1'b1;
                  end else begin
                    state_q <= PLAY_REST;
                    dur_q   <= REST_LOAD;
                  end
                end
              end
              default: begin
                if (dur_q != '0) begin
                  dur_q <= dur_q - CNT_W'(1);
                end else begin
                  state_q        <= PLAY_LOAD;
                  next_note_en_q <= 1'b1;
                  display_note_q <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign ld_note      = ld_note_q;
  assign ld_play      = ld_play_q;
  assign next_note_en = next_note_en_q;
  assign display_note = display_note_q;
  assign tone_en      = tone_en_q;
  assign note_counter = note_counter_q;
  assign note_total   = note_total_q;
  assign full         = full_w;
  assign state        = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with NOTE_TICKS=4, REST_TICKS=2.
module tb_music_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       record_req = 1'b0;
  logic       play_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       note_strobe = 1'b0;
  logic       ld_note;
  logic       ld_play;
  logic       next_note_en;
  logic [3:0] note_counter;
  logic       display_note;
  logic       tone_en;
  logic [4:0] note_total;
  logic       full;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int ld_cnt  = 0;
  int base;

  music_sequencer #(
    .NOTE_TICKS(4),
    .REST_TICKS(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .record_req(record_req),
    .play_req(play_req),
    .stop_req(stop_req),
    .note_strobe(note_strobe),
    .ld_note(ld_note),
    .ld_play(ld_play),
    .next_note_en(next_note_en),
    .note_counter(note_counter),
    .display_note(display_note),
    .tone_en(tone_en),
    .note_total(note_total),
    .full(full),
    .state(state)
  );

  always #5 clk = ~clk;

  // Count write pulses mid-cycle.
  always @(negedge clk) if (ld_note === 1'b1) ld_cnt <= ld_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    note_strobe = 1'b1;
    tick();
    note_strobe = 1'b0;
  endtask

  task automatic pulse_req(input int which);
    if (which == 0) record_req = 1'b1;
    if (which == 1) play_req = 1'b1;
    if (which == 2) stop_req = 1'b1;
    tick();
    record_req = 1'b0;
    play_req   = 1'b0;
    stop_req   = 1'b0;
  endtask

  initial begin
    // Reset held three cycles.
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_ld_note", 32'(ld_note), 0);
    chk("rst_ld_play", 32'(ld_play), 0);
    chk("rst_nne", 32'(next_note_en), 0);
    chk("rst_cnt", 32'(note_counter), 0);
    chk("rst_disp", 32'(display_note), 0);
    chk("rst_tone", 32'(tone_en), 0);
    chk("rst_total", 32'(note_total), 0);
    chk("rst_full", 32'(full), 0);
    reset = 1'b1;
    tick();

    // Play with nothing stored is ignored.
    pulse_req(1);
    chk("empty_play_ld_play", 32'(ld_play), 0);
    chk("empty_play_state", 32'(state), 0);

    // Record three notes, strobes 5 cycles apart.
    pulse_req(0);
    chk("rec_state", 32'(state), 1);
    for (int k = 1; k <= 3; k++) begin
      strobe();
      chk("rec_ld_note_hi", 32'(ld_note), 1);
      chk("rec_total", 32'(note_total), 32'(k));
      tick();
      chk("rec_ld_note_lo", 32'(ld_note), 0);
      repeat (3) tick();
    end
    pulse_req(2);
    chk("rec_stop_state", 32'(state), 0);

    // Full playback of three notes: 8-cycle period per note.
    pulse_req(1);
    for (int k = 0; k < 22; k++) begin
      int i;
      int c;
      i = k / 8;
      c = k % 8;
      chk("play_nne", 32'(next_note_en), 32'(c == 0));
      chk("play_tone", 32'(tone_en), 32'(c >= 2 && c <= 5));
      chk("play_cnt", 32'(note_counter), 32'((c >= 6) ? i + 1 : i));
      chk("play_ld_play", 32'(ld_play), 1);
      tick();
    end
    chk("end_ld_play", 32'(ld_play), 0);
    chk("end_state", 32'(state), 0);
    chk("end_cnt", 32'(note_counter), 2);
    chk("end_tone", 32'(tone_en), 0);

    // Stop during note 1 -> park cycle, then IDLE.
    pulse_req(1);
    repeat (11) tick();
    chk("stop_pre_tone", 32'(tone_en), 1);
    chk("stop_pre_cnt", 32'(note_counter), 1);
    pulse_req(2);
    chk("park_nne", 32'(next_note_en), 1);
    chk("park_cnt", 32'(note_counter), 2);
    chk("park_tone", 32'(tone_en), 0);
    chk("park_ld_play", 32'(ld_play), 1);
    chk("park_state", 32'(state), 0);
    tick();
    chk("post_park_ld_play", 32'(ld_play), 0);
    chk("post_park_nne", 32'(next_note_en), 0);
    pulse_req(0);
    strobe();
    chk("append_ld_note", 32'(ld_note), 1);
    chk("append_total", 32'(note_total), 4);
    repeat (2) tick();

    // Play and stop together in IDLE -> stays IDLE.
    pulse_req(2);
    play_req = 1'b1;
    stop_req = 1'b1;
    tick();
    play_req = 1'b0;
    stop_req = 1'b0;
    chk("ps_state", 32'(state), 0);
    chk("ps_ld_play", 32'(ld_play), 0);
    chk("ps_nne", 32'(next_note_en), 0);

    // Reset during PLAY_HOLD.
    pulse_req(1);
    repeat (2) tick();
    chk("hold_tone", 32'(tone_en), 1);
    reset = 1'b0;
    tick();
    chk("mid_rst_tone", 32'(tone_en), 0);
    chk("mid_rst_ld_play", 32'(ld_play), 0);
    chk("mid_rst_nne", 32'(next_note_en), 0);
    chk("mid_rst_total", 32'(note_total), 0);
    chk("mid_rst_state", 32'(state), 0);
    reset = 1'b1;
    tick();

    // Strobe repeated one cycle later is dropped.
    pulse_req(0);
    base = ld_cnt;
    note_strobe = 1'b1;
    tick();
    tick();
    note_strobe = 1'b0;
    repeat (2) tick();
    chk("dbl_strobe_pulses", 32'(ld_cnt - base), 1);
    chk("dbl_strobe_total", 32'(note_total), 1);

    // Fill memory: 17 strobes -> 16 writes.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pulse_req(0);
    base = ld_cnt;
    for (int j = 0; j < 17; j++) begin
      strobe();
      repeat (2) tick();
    end
    chk("fill_pulses", 32'(ld_cnt - base), 16);
    chk("fill_total", 32'(note_total), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_state", 32'(state), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
